cpu_control_unit: RTL

Instruction sequencer that drives the 8-bit ALU/accumulator datapath. It fetches bytes from a synchronous program ROM, decodes them, and issues alu_op, ce_cy, write strobes and register selects to the datapath. It consumes the datapath's carry and zero flags for conditional jumps. Sits between program ROM and datapath as the sole initiator of ALU operations.

---
 rtl/cpu_control_unit_if.sv | 28 ++
 rtl/cpu_control_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/cpu_control_unit_if.sv
// Bus between the instruction sequencer, its program ROM and the ALU/accumulator datapath.
// The sequencer side uses the master modport; ROM and datapath together use the slave modport.
interface cpu_control_unit_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              cy;
    logic              zf;
    logic [2:0]        alu_op;
    logic              ce_cy;
    logic              a_we;
    logic              rf_we;
    logic [2:0]        rf_sel;
    logic              imm_sel;
    logic [7:0]        imm;
    logic              halted;

    modport master (
        output rom_addr, alu_op, ce_cy, a_we, rf_we, rf_sel, imm_sel, imm, halted,
        input  rom_data, cy, zf
    );

    modport slave (
        input  rom_addr, alu_op, ce_cy, a_we, rf_we, rf_sel, imm_sel, imm, halted,
        output rom_data, cy, zf
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Instruction sequencer for the 8-bit ALU/accumulator datapath.
// Optional feature macro CALL_RET_EN adds a one-entry return register for CALL/RET.
module cpu_control_unit #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst,
    cpu_control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_IMM_WAIT,
        S_IMM,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [7:0]        imm_q, imm_d;
`ifdef CALL_RET_EN
    logic [ADDR_W-1:0] ret_q, ret_d;
`endif

    logic [2:0] alu_op_c;
    logic       ce_cy_c;
    logic       a_we_c;
    logic       rf_we_c;
    logic [2:0] rf_sel_c;
    logic       imm_sel_c;

    logic [2:0] ir_f;
    logic [1:0] ir_cls;
    logic [2:0] ir_n;

    assign ir_f   = ir_q[7:5];
    assign ir_cls = ir_q[4:3];
    assign ir_n   = ir_q[2:0];

    // Opcodes followed by an operand byte: LDI, the four jumps, and CALL when enabled.
    function automatic logic is_two_byte(input logic [7:0] op);
        logic two;
        two = 1'b0;
        if (op[4:3] == 2'b01 && op[7:5] == 3'b001) two = 1'b1;
        if (op[4:3] == 2'b11 && op[7] == 1'b0)     two = 1'b1;
`ifdef CALL_RET_EN
        if (op[4:3] == 2'b11 && op[7:5] == 3'b101) two = 1'b1;
`endif
        return two;
    endfunction

    function automatic logic is_halt(input logic [7:0] op);
        return (op[4:3] == 2'b11) && (op[7:5] == 3'b111);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
            imm_q   <= 8'h00;
`ifdef CALL_RET_EN
            ret_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            imm_q   <= imm_d;
`ifdef CALL_RET_EN
            ret_q   <= ret_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        imm_d     = imm_q;
`ifdef CALL_RET_EN
        ret_d     = ret_q;
`endif
        alu_op_c  = 3'b110;
        ce_cy_c   = 1'b0;
        a_we_c    = 1'b0;
        rf_we_c   = 1'b0;
        rf_sel_c  = 3'b000;
        imm_sel_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            // ir is not loaded yet, so the branch is taken on the raw ROM byte.
            S_DECODE: begin
                ir_d = bus.rom_data;
                pc_d = pc_q + ADDR_W'(1);
                if (is_halt(bus.rom_data))
                    state_d = S_HALT;
                else if (is_two_byte(bus.rom_data))
                    state_d = S_IMM_WAIT;
                else
                    state_d = S_EXEC;
            end
            S_IMM_WAIT: begin
                state_d = S_IMM;
            end
            S_IMM: begin
                imm_d   = bus.rom_data;
                pc_d    = pc_q + ADDR_W'(1);
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (ir_cls)
                    2'b00: begin
                        alu_op_c = ir_f;
                        rf_sel_c = ir_n;
                        a_we_c   = 1'b1;
                        ce_cy_c  = 1'b1;
                    end
                    2'b01: begin
                        if (ir_f == 3'b000) begin
                            rf_we_c  = 1'b1;
                            rf_sel_c = ir_n;
                        end else if (ir_f == 3'b001) begin
                            imm_sel_c = 1'b1;
                            a_we_c    = 1'b1;
                        end
                    end
                    2'b11: begin
                        case (ir_f)
                            3'b000: pc_d = imm_q[ADDR_W-1:0];
                            3'b001: if (bus.cy)  pc_d = imm_q[ADDR_W-1:0];
                            3'b010: if (!bus.cy) pc_d = imm_q[ADDR_W-1:0];
                            3'b011: if (bus.zf)  pc_d = imm_q[ADDR_W-1:0];
`ifdef CALL_RET_EN
                            3'b101: begin
                                ret_d = pc_q;
                                pc_d  = imm_q[ADDR_W-1:0];
                            end
                            3'b110: pc_d = ret_q;
`endif
                            default: ;
                        endcase
                    end
                    default: ;
                endcase
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign bus.rom_addr = pc_q;
    assign bus.alu_op   = alu_op_c;
    assign bus.ce_cy    = ce_cy_c;
    assign bus.a_we     = a_we_c;
    assign bus.rf_we    = rf_we_c;
    assign bus.rf_sel   = rf_sel_c;
    assign bus.imm_sel  = imm_sel_c;
    assign bus.imm      = imm_q;
    assign bus.halted   = (state_q == S_HALT);

endmodule
